seg_scan_ctrl: RTL

//  Parametrised time-multiplexed 7-segment display scanner for the board display path.

---
 rtl/seg_scan_ctrl_if.sv | 52 +++++
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
//   Bundles the digit-data inputs and the display-drive outputs of the
//   7-segment scanner.
//   Optional feature macro: BRIGHTNESS_PWM_EN adds the 4-bit brightness signal.
//
//   Signals
//     digit_data  [4*N_DIGITS]  hex nibble per digit, digit k = [4k+3:4k]
//     dp_in       [N_DIGITS]    decimal point per digit, 1 = lit
//     digit_en    [N_DIGITS]    per-digit enable, 0 = blanked
//     blank_all                 1 = all anodes off, applied live
//     brightness  [4]           PWM duty, 15 = full (BRIGHTNESS_PWM_EN only)
//     an          [N_DIGITS]    anodes, active-low
//     seg         [7]           segments {g,f,e,d,c,b,a}, active-low
//     dp_n                      decimal point, active-low
//     frame_start               one-cycle pulse when the scan wraps to digit 0
//
//   Modports
//     master : drives the digit data and observes the display outputs
//     slave  : the scanner itself
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] digit_data;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  blank_all;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]            brightness;
`endif
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  dp_n;
  logic                  frame_start;

  modport master (
`ifdef BRIGHTNESS_PWM_EN
    output brightness,
`endif
    output digit_data, dp_in, digit_en, blank_all,
    input  an, seg, dp_n, frame_start
  );

  modport slave (
`ifdef BRIGHTNESS_PWM_EN
    input  brightness,
`endif
    input  digit_data, dp_in, digit_en, blank_all,
    output an, seg, dp_n, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed 7-segment display scanner. One anode is driven per
//   refresh slot; the slot's hex nibble is decoded to active-low segments.
//   A whole frame of digit data is snapshotted at the frame boundary so the
//   display never tears mid-scan. Each slot starts with GUARD_CYC cycles of
//   all anodes off to suppress ghosting while segments change.
//
//   Optional feature macro: BRIGHTNESS_PWM_EN
//     Adds a free-running 4-bit PWM counter; a digit is lit only while
//     pwm_cnt <= brightness (latched with the frame snapshot).
//
//   Ports
//     clk      : system clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : seg_scan_ctrl_if.slave (digit data in, display drive out)
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Active-low gfedcba hex decoder.
  function automatic logic [6:0] dec7(input logic [3:0] nib);
    case (nib)
      4'h0: dec7 = 7'h40;  4'h1: dec7 = 7'h79;
      4'h2: dec7 = 7'h24;  4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;  4'h5: dec7 = 7'h12;
      4'h6: dec7 = 7'h02;  4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;  4'h9: dec7 = 7'h10;
      4'hA: dec7 = 7'h08;  4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46;  4'hD: dec7 = 7'h21;
      4'hE: dec7 = 7'h06;  default: dec7 = 7'h0E;
    endcase
  endfunction

  logic [PS_W-1:0]             prescaler_q, prescaler_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        frame_valid_q;
  logic [N_DIGITS-1:0][3:0]    snap_data_q;
  logic [N_DIGITS-1:0]         snap_dp_q;
  logic [N_DIGITS-1:0]         snap_en_q;
  logic [N_DIGITS-1:0]         an_q, an_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_n_q, dp_n_d;
  logic                        frame_start_q;

  logic tick, wrap, load, guard_ok, pwm_ok, lit;

  assign tick = (prescaler_q == PS_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);
  // First clock after reset fills the snapshot; afterwards only at frame end.
  assign load = !frame_valid_q || wrap;

  generate
    if (GUARD_CYC == 0) begin : g_noguard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (prescaler_q >= PS_W'(GUARD_CYC));
    end
  endgenerate

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] pwm_cnt_q;
  logic [3:0] snap_bright_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q     <= 4'd0;
      snap_bright_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      if (load) snap_bright_q <= bus.brightness;
    end
  end

  assign pwm_ok = (pwm_cnt_q <= snap_bright_q);
`else
  assign pwm_ok = 1'b1;
`endif

  assign lit = frame_valid_q && !bus.blank_all && snap_en_q[idx_q] && guard_ok && pwm_ok;

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    idx_d       = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (lit) begin
      an_d   = ~(N_DIGITS'(1) << idx_q);
      seg_d  = dec7(snap_data_q[idx_q]);
      dp_n_d = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q   <= '0;
      idx_q         <= '0;
      frame_valid_q <= 1'b0;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      frame_valid_q <= 1'b1;
      if (load) begin
        snap_data_q <= bus.digit_data;
        snap_dp_q   <= bus.dp_in;
        snap_en_q   <= bus.digit_en;
      end
      // Display outputs lag prescaler/idx by one cycle.
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= wrap;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_start = frame_start_q;

endmodule
